// File: rtl/pwconv_pkg.sv
// -----------------------------------------------------------------------------
// pwconv_pkg
// Shared definitions for the pointwise-conv accumulate path:
//   - default widths for products/bias (IN_W), output (OUT_W), accumulator (ACC_W)
//   - clog2 constant function used to size the adder tree and group counter
//   - signed saturation helper (value up to SAT_W bits -> OUT_W range + clamp flag)
// No ports (package).
// -----------------------------------------------------------------------------
package pwconv_pkg;

  localparam int unsigned IN_W_DEF  = 32;
  localparam int unsigned OUT_W_DEF = 32;
  localparam int unsigned ACC_W_DEF = 48;

  // Working width of the saturation helper; accumulators up to this width fit.
  localparam int unsigned SAT_W = 64;

  typedef struct packed {
    logic             clamp;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 32'd0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) begin
        r = i + 32'd1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Clamp a signed value to the signed range of out_w bits; val stays sign-extended.
  function automatic sat_res_t sat_signed(input logic signed [SAT_W-1:0] v,
                                          input int unsigned out_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    hi = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      res.clamp = 1'b1;
      res.val   = hi;
    end else if (v < lo) begin
      res.clamp = 1'b1;
      res.val   = lo;
    end else begin
      res.clamp = 1'b0;
      res.val   = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwconv_adder_tree_pipe.sv
// -----------------------------------------------------------------------------
// pwconv_adder_tree_pipe
// Pipelined signed adder tree: an entry register stage (lanes sign-extended to
// ACC_W, padded with zero up to a power of two) followed by clog2(NUM_IN)
// registered adder levels. Valid and an opaque tag travel alongside the data.
// Ports:
//   clk, rst_b      clock, asynchronous active-low reset
//   clear_i         synchronous flush of all pipeline valids
//   valid_i, data_i beat valid and NUM_IN packed signed IN_W lanes
//   tag_i           side-band tag carried with the beat
//   valid_o, sum_o  tree output valid and ACC_W sum (LVL+1 cycles after entry)
//   tag_o           tag aligned with sum_o
// -----------------------------------------------------------------------------
module pwconv_adder_tree_pipe
  import pwconv_pkg::*;
#(
  parameter int unsigned NUM_IN = 8,
  parameter int unsigned IN_W   = IN_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned TAG_W  = 1
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   clear_i,
  input  logic                   valid_i,
  input  logic [NUM_IN*IN_W-1:0] data_i,
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   valid_o,
  output logic [ACC_W-1:0]       sum_o,
  output logic [TAG_W-1:0]       tag_o
);

  localparam int unsigned LVL = clog2(NUM_IN);
  localparam int unsigned NP  = 32'd1 << LVL;
  localparam int unsigned STG = LVL + 32'd1;

  // Heap layout: node 0 is the root, children of node i are 2i+1 and 2i+2;
  // indices NP-1 .. 2NP-2 are the leaves (held in leaf_q).
  logic [ACC_W-1:0] leaf_d [NP];
  logic [ACC_W-1:0] leaf_q [NP];
  logic [ACC_W-1:0] node_d [NP-1];
  logic [ACC_W-1:0] node_q [NP-1];
  logic [STG-1:0]   vld_q;
  logic [TAG_W-1:0] tag_q  [STG];

  for (genvar k = 0; k < NP; k++) begin : g_leaf
    if (k < NUM_IN) begin : g_lane
      assign leaf_d[k] = ACC_W'($signed(data_i[k*IN_W +: IN_W]));
    end else begin : g_pad
      assign leaf_d[k] = '0;
    end
  end

  for (genvar i = 0; i < NP - 1; i++) begin : g_node
    if (2 * i + 1 >= NP - 1) begin : g_from_leaf
      assign node_d[i] = leaf_q[2*i+1-(NP-1)] + leaf_q[2*i+2-(NP-1)];
    end else begin : g_from_node
      assign node_d[i] = node_q[2*i+1] + node_q[2*i+2];
    end
  end

  // Entry stage, adder levels and valid/tag shift register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int j = 0; j < NP; j++)      leaf_q[j] <= '0;
      for (int j = 0; j < NP - 1; j++)  node_q[j] <= '0;
      for (int j = 0; j < STG; j++)     tag_q[j]  <= '0;
      vld_q <= '0;
    end else begin
      leaf_q   <= leaf_d;
      node_q   <= node_d;
      tag_q[0] <= tag_i;
      for (int j = 1; j < STG; j++) tag_q[j] <= tag_q[j-1];
      if (clear_i) begin
        vld_q <= '0;
      end else begin
        vld_q <= {vld_q[STG-2:0], valid_i};
      end
    end
  end

  assign valid_o = vld_q[STG-1];
  assign sum_o   = node_q[0];
  assign tag_o   = tag_q[STG-1];

endmodule

// File: rtl/pwconv_accum_tree.sv
// -----------------------------------------------------------------------------
// pwconv_accum_tree
// Sums NUM_IN signed products per beat through a pipelined adder tree, then
// accumulates NUM_GROUPS consecutive beats (plus the bias of the first beat)
// into one output point, with optional ReLU and saturation to OUT_W.
// Ports:
//   clk, rst_b      clock, asynchronous active-low reset
//   clear           synchronous flush of in-flight frames (wins over in_valid)
//   in_valid        beat valid (no backpressure)
//   data_in         NUM_IN packed signed products, lane k = [k*IN_W +: IN_W]
//   bias            signed bias, used only on group-0 beats
//   out_valid       one-cycle pulse per completed point
//   data_out        saturated result, held between pulses
//   sat             result was clamped (meaningful with out_valid, then held)
// -----------------------------------------------------------------------------
module pwconv_accum_tree
  import pwconv_pkg::*;
#(
  parameter int unsigned NUM_IN     = 8,
  parameter int unsigned IN_W       = IN_W_DEF,
  parameter int unsigned ACC_W      = ACC_W_DEF,
  parameter int unsigned OUT_W      = OUT_W_DEF,
  parameter int unsigned NUM_GROUPS = 4,
  parameter int unsigned RELU_EN    = 0
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [NUM_IN*IN_W-1:0] data_in,
  input  logic [IN_W-1:0]        bias,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       data_out,
  output logic                   sat
);

  localparam int unsigned GRP_W = (NUM_GROUPS > 1) ? clog2(NUM_GROUPS) : 32'd1;
  localparam int unsigned TAG_W = IN_W + 32'd2;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(NUM_GROUPS - 32'd1);

  logic [GRP_W-1:0]        grp_q, grp_d;
  logic                    accept_s, first_s, last_s;
  logic [TAG_W-1:0]        tag_in_s, tag_out_s;
  logic                    tree_vld_s;
  logic [ACC_W-1:0]        tree_sum_s;
  logic                    tag_first_s, tag_last_s;
  logic signed [IN_W-1:0]  tag_bias_s;
  logic signed [ACC_W-1:0] acc_q, acc_d, base_s, nxt_s, relu_s;
  sat_res_t                sat_res_s;
  logic                    out_valid_q, out_valid_d;
  logic                    sat_q, sat_d;
  logic [OUT_W-1:0]        data_q, data_d;

  // Input group counter and the first/last/bias tag that rides the tree.
  always_comb begin
    accept_s = in_valid & ~clear;
    first_s  = (grp_q == '0);
    last_s   = (grp_q == GRP_LAST);
    // Bias is only meaningful on the first beat; zero it otherwise.
    tag_in_s = {first_s, last_s, first_s ? bias : {IN_W{1'b0}}};
    grp_d    = grp_q;
    if (clear) begin
      grp_d = '0;
    end else if (accept_s) begin
      if (last_s) begin
        grp_d = '0;
      end else begin
        grp_d = grp_q + GRP_W'(1'b1);
      end
    end else begin
      grp_d = grp_q;
    end
  end

  pwconv_adder_tree_pipe #(
    .NUM_IN (NUM_IN),
    .IN_W   (IN_W),
    .ACC_W  (ACC_W),
    .TAG_W  (TAG_W)
  ) u_tree (
    .clk     (clk),
    .rst_b   (rst_b),
    .clear_i (clear),
    .valid_i (accept_s),
    .data_i  (data_in),
    .tag_i   (tag_in_s),
    .valid_o (tree_vld_s),
    .sum_o   (tree_sum_s),
    .tag_o   (tag_out_s)
  );

  // Accumulate, ReLU and saturate the partial sum leaving the tree.
  always_comb begin
    tag_first_s = tag_out_s[TAG_W-1];
    tag_last_s  = tag_out_s[TAG_W-2];
    tag_bias_s  = signed'(tag_out_s[IN_W-1:0]);
    if (tag_first_s) begin
      base_s = ACC_W'(tag_bias_s);
    end else begin
      base_s = acc_q;
    end
    nxt_s = base_s + signed'(tree_sum_s);
    if ((RELU_EN != 0) && nxt_s[ACC_W-1]) begin
      relu_s = '0;
    end else begin
      relu_s = nxt_s;
    end
    sat_res_s   = sat_signed(SAT_W'(relu_s), OUT_W);
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    data_d      = data_q;
    sat_d       = sat_q;
    if (clear) begin
      acc_d = '0;
    end else if (tree_vld_s) begin
      if (tag_last_s) begin
        acc_d       = '0;
        out_valid_d = 1'b1;
        data_d      = OUT_W'(sat_res_s.val);
        sat_d       = sat_res_s.clamp;
      end else begin
        acc_d = nxt_s;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Group counter, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      grp_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      grp_q       <= grp_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign sat       = sat_q;

endmodule

// File: doc/pwconv_accum_tree.md
Name: pwconv_accum_tree

Overview:
- Parametrised, pipelined successor of the pointwise-conv 1-point adder.
- Sums NUM_IN signed products per beat with a registered adder tree.
- Accumulates NUM_GROUPS consecutive beats (input-channel groups) into one output point, adding the per-point bias once.
- Applies optional ReLU, then saturates to OUT_W.
- Sits between the PW multiplier array and the output feature buffer; streaming, no backpressure.

Parameters:
- NUM_IN, 8: products per beat; must be >= 2.
- IN_W, 32: signed width of each product and of bias.
- ACC_W, 48: internal tree/accumulator width; must be >= IN_W + clog2(NUM_IN*NUM_GROUPS) + 1.
- OUT_W, 32: signed output width; must be <= ACC_W.
- NUM_GROUPS, 4: beats accumulated per output point; must be >= 1.
- RELU_EN, 0: 1 = clamp negative results to 0 before saturation.

Ports:
- clk  in  1  clock.
- rst_b  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush; drops in-flight frames.
- in_valid  in  1  beat valid.
- data_in  in  NUM_IN*IN_W  packed signed products; lane k = bits [k*IN_W +: IN_W].
- bias  in  IN_W  signed bias; sampled only on group-0 beats.
- out_valid  out  1  one-cycle pulse per completed point.
- data_out  out  OUT_W  signed result; held between pulses.
- sat  out  1  qualified by out_valid; 1 = result was clamped by saturation.

Behaviour:
- Reset (rst_b low, async): out_valid=0, data_out=0, sat=0; all pipeline valids, group counter and accumulator cleared.
- LVL = clog2(NUM_IN).
- Tree: LVL registered levels.
  - Odd operand counts are padded with 0.
  - Lanes are sign-extended to ACC_W at entry.
- Input group counter in_grp runs 0..NUM_GROUPS-1. It advances on each accepted beat and wraps to 0.
- Each accepted beat carries side-band tags through the tree: first = (in_grp==0), last = (in_grp==NUM_GROUPS-1), and bias when first.
- With NUM_GROUPS=1, every beat is both first and last.
- Accumulator stage, on the edge after the partial sum leaves the tree:
  - nxt = (first ? sext(bias) : acc) + partial.
  - If !last: acc <= nxt.
  - If last: acc <= 0. data_out <= sat(relu(nxt)); sat <= clamp occurred; out_valid <= 1.
- Latency: beat accepted at edge t gives out_valid high after edge t+LVL+1, for the last beat of a frame.
- Throughput: one beat per cycle, back-to-back frames allowed. There are no bubbles and no stalls.
- ReLU (RELU_EN=1): nxt<0 gives 0, with sat=0.
- Saturation: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. No wrap-around ever reaches data_out.
- out_valid is low on every cycle without a completed point.
- data_out and sat hold their last values when out_valid is low.
- clear (sampled at clk edge):
  - Zeroes in_grp, acc, all pipeline valids, and out_valid on the next cycle.
  - data_out and sat hold.
  - clear and in_valid in the same cycle: clear wins and the beat is dropped.
  - The next accepted beat is group 0.
- in_valid low mid-frame: the frame simply pauses and the group count is preserved.
- Reset mid-frame: the partial frame is discarded. The first beat after reset is group 0.

Decomposition:
- Shared package pwconv_pkg holds:
  - clog2 constant function.
  - Signed saturate function (ACC_W to OUT_W, returns value and clamp flag).
  - Default widths IN_W/OUT_W/ACC_W.
- Sub-module pwconv_adder_tree_pipe: NUM_IN, IN_W, ACC_W, TAG_W parameters; registered levels; valid and tag pass-through; honours clear.
- The accumulate / ReLU / saturate stage stays in the top module.

Test Plan:
- NUM_IN=8, NUM_GROUPS=1, RELU_EN=0; all lanes 1, bias 10, one beat -> out_valid exactly 4 cycles later, data_out=18, sat=0.
- NUM_GROUPS=4; four beats with all lanes 2, bias -5 on beat 0 and 1000 on beats 1-3 -> single out_valid 4 cycles after beat 3, data_out=59; no pulse earlier.
- OUT_W=32; eight lanes 0x7FFFFFFF, bias 0 -> data_out=0x7FFFFFFF, sat=1. Eight lanes 0x80000000 -> data_out=0x80000000, sat=1.
- RELU_EN=1, NUM_GROUPS=1; lanes sum -100, bias 0 -> data_out=0, sat=0. Lanes sum 7 -> data_out=7.
- NUM_GROUPS=4, 8 continuous beats with lanes=1; bias 3 for frame A and 9 for frame B -> two pulses 4 cycles apart, data_out 35 then 41.
- Two beats, then clear, then 4 beats with lanes=1, bias 0 -> one pulse, data_out=32. Repeat with rst_b low mid-frame -> outputs 0, and the next full frame gives the correct result.
